// File: rtl/sigma_delta_adc.sv
// First-order delta-sigma ADC front end with CIC3 decimator.
// Ports: clk, rst (sync, high), cmp_in (async comparator), fb_out (feedback
// pulse), dout/dout_valid/ovr (decimated signed sample, strobe, saturation).
module sigma_delta_adc #(
  parameter int DECIM_LOG2 = 8,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_in,
  output logic             fb_out,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             ovr
);

  localparam int W  = 3*DECIM_LOG2 + 2;
  localparam int SH = 3*DECIM_LOG2 - (OUT_W-1);

  localparam logic signed [W-1:0] MAXV =
    W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [W-1:0] MINV =
    W'(-(64'sd1 <<< (OUT_W-1)));

  logic s1, s2;
  logic signed [W-1:0] xw;
  logic signed [W-1:0] i1, i2, i3;
  logic signed [W-1:0] d1, d2, d3;
  logic signed [W-1:0] c1, c2, c3;
  logic signed [W-1:0] y;
  logic [DECIM_LOG2-1:0] cnt;
  logic [1:0] warm;
  logic tick;
  logic [OUT_W-1:0] sat_val;
  logic sat_ovr;

  assign fb_out = s2;
  assign xw     = s2 ? W'(1) : '1;
  assign tick   = (cnt == '1);

  // Comb chain is evaluated combinationally from i3 and
  // only the differential-delay registers advance on tick.
  assign c1 = i3 - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;
  assign y  = c3 >>> SH;

  always_comb begin
    sat_val = y[OUT_W-1:0];
    sat_ovr = 1'b0;
    if (y > MAXV) begin
      sat_val = MAXV[OUT_W-1:0];
      sat_ovr = 1'b1;
    end else if (y < MINV) begin
      sat_val = MINV[OUT_W-1:0];
      sat_ovr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      cnt        <= '0;
      warm       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      s1         <= cmp_in;
      s2         <= s1;
      i1         <= i1 + xw;
      i2         <= i2 + i1;
      i3         <= i3 + i2;
      cnt        <= cnt + 1'b1;
      dout_valid <= 1'b0;
      if (tick) begin
        d1 <= i3;
        d2 <= c1;
        d3 <= c2;
        // The first three decimated outputs are built from
        // partially filled integrators, so they are dropped.
        if (warm != 2'd3) begin
          warm <= warm + 2'd1;
        end else begin
          dout       <= sat_val;
          ovr        <= sat_ovr;
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Self-checking bench for sigma_delta_adc.
// Scoreboard of expected sample ranges, popped on each strobe.
module tb_sigma_delta_adc;

  localparam int OW = 16;
  localparam int R  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_in = 1'b0;
  logic fb_out;
  logic [OW-1:0] dout;
  logic dout_valid;
  logic ovr;

  sigma_delta_adc #(.DECIM_LOG2(8), .OUT_W(OW)) dut (
    .clk(clk),
    .rst(rst),
    .cmp_in(cmp_in),
    .fb_out(fb_out),
    .dout(dout),
    .dout_valid(dout_valid),
    .ovr(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   lo;
    int   hi;
    logic o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   pass_n = 0;
  int   tot_n  = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  int   smax   = -100000;
  int   smin   = 100000;
  int   sv;

  // stimulus modes: 0 const0, 1 const1, 2 alternate,
  // 3 pattern 1110, 4 loop DC 0.25 FS, 5 loop sine
  int   mode = 2;
  int   ph   = 0;
  int   v    = 0;
  int   vin  = 0;
  real  ang;

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(negedge clk);
      ph++;
      case (mode)
        0: cmp_in = 1'b0;
        1: cmp_in = 1'b1;
        2: cmp_in = ph[0];
        3: cmp_in = (ph % 4) != 3;
        default: begin
          if (mode == 4) begin
            vin = 1024;
          end else begin
            ang = 2.0 * 3.14159265358979 * real'(ph % 4096) / 4096.0;
            vin = $rtoi(2048.0 * $sin(ang));
          end
          v = v + vin - (fb_out ? 4096 : -4096);
          cmp_in = (v > 0);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (dout_valid && mon_en) begin
      tot_n++;
      sv = int'($signed(dout));
      if (sb.size() == 0) begin
        $display("FAIL unexpected_strobe: dout=%0d ovr=%0b, none expected",
                 sv, ovr);
      end else begin
        e = sb.pop_front();
        if (sv > smax) smax = sv;
        if (sv < smin) smin = sv;
        if (sv < e.lo || sv > e.hi || ovr !== e.o)
          $display("FAIL sample@%0d: dout=%0d ovr=%0b, want [%0d,%0d] ovr=%0b",
                   cyc, sv, ovr, e.lo, e.hi, e.o);
        else
          pass_n++;
      end
    end
  end

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (dout_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic collect(input int n, output int got);
    bit ok;
    got = 0;
    for (int k = 0; k < n; k++) begin
      wait_valid(R + 40, ok);
      if (ok) got++;
    end
    @(negedge clk);
  endtask

  task automatic push(input int n, input int lo, input int hi, input logic o);
    exp_t x;
    x.lo = lo;
    x.hi = hi;
    x.o  = o;
    for (int k = 0; k < n; k++) sb.push_back(x);
  endtask

  task automatic switch_mode(input int m);
    int got;
    mon_en = 1'b0;
    mode = m;
    v = 0;
    collect(5, got);
    tot_n++;
    if (got != 5) $display("FAIL settle_%0d: strobes=%0d, want 5", m, got);
    else pass_n++;
  endtask

  task automatic test_reset;
    int nstr;
    rst = 1'b1;
    mode = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tot_n++;
      if ({fb_out, dout_valid, ovr} !== 3'b000 || dout !== '0)
        $display("FAIL reset_hold%0d: fb=%0b dv=%0b ovr=%0b dout=%0h, want 0",
                 k, fb_out, dout_valid, ovr, dout);
      else
        pass_n++;
    end
    mode = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(4, 32767, 32767, 1'b1);
    mon_en = 1'b1;
    nstr = 0;
    for (int k = 1; k <= 4*R; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tot_n++;
        if (fb_out !== 1'b0) $display("FAIL fb_clk1: fb=%0b, want 0", fb_out);
        else pass_n++;
      end
      if (k == 2) begin
        tot_n++;
        if (fb_out !== 1'b1) $display("FAIL fb_clk2: fb=%0b, want 1", fb_out);
        else pass_n++;
      end
      if (k < 4*R && dout_valid) nstr++;
      if (k == 4*R) begin
        tot_n++;
        if (dout_valid !== 1'b1)
          $display("FAIL first_strobe: dv=%0b at clk %0d, want 1", dout_valid, k);
        else
          pass_n++;
      end
    end
    tot_n++;
    if (nstr != 0) $display("FAIL warmup: strobes=%0d, want 0", nstr);
    else pass_n++;
  endtask

  task automatic test_period(input string nm);
    bit ok;
    int prev;
    prev = cyc;
    for (int j = 0; j < 3; j++) begin
      wait_valid(R + 40, ok);
      tot_n++;
      if (!ok || cyc - prev != R)
        $display("FAIL %s_period%0d: gap=%0d ok=%0b, want %0d",
                 nm, j, cyc - prev, ok, R);
      else
        pass_n++;
      prev = cyc;
    end
    @(negedge clk);
    tot_n++;
    if (sb.size() != 0) $display("FAIL %s_drain: left=%0d, want 0", nm, sb.size());
    else pass_n++;
  endtask

  task automatic test_const(input int m, input int val, input logic o);
    int got;
    switch_mode(m);
    push(3, val, val, o);
    mon_en = 1'b1;
    collect(3, got);
    tot_n++;
    if (got != 3 || sb.size() != 0)
      $display("FAIL const_mode%0d: strobes=%0d left=%0d, want 3/0",
               m, got, sb.size());
    else
      pass_n++;
  endtask

  task automatic test_mid_reset;
    bit ok;
    int nstr;
    switch_mode(3);
    wait_valid(R + 40, ok);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tot_n++;
    if (dout !== '0 || dout_valid !== 1'b0 || ovr !== 1'b0)
      $display("FAIL midrst_clear: dout=%0h dv=%0b ovr=%0b, want 0",
               dout, dout_valid, ovr);
    else
      pass_n++;
    rst = 1'b0;
    push(4, 16384, 16384, 1'b0);
    mon_en = 1'b1;
    nstr = 0;
    for (int k = 1; k <= 4*R; k++) begin
      @(negedge clk);
      if (k < 4*R && dout_valid) nstr++;
      if (k == 4*R) begin
        tot_n++;
        if (dout_valid !== 1'b1)
          $display("FAIL midrst_first: dv=%0b, want 1", dout_valid);
        else
          pass_n++;
      end
    end
    tot_n++;
    if (nstr != 0) $display("FAIL midrst_warmup: strobes=%0d, want 0", nstr);
    else pass_n++;
    test_period("midrst");
  endtask

  task automatic test_closed_loop;
    int got;
    switch_mode(4);
    push(3, 8192 - 64, 8192 + 64, 1'b0);
    mon_en = 1'b1;
    collect(3, got);
    tot_n++;
    if (got != 3) $display("FAIL loop_dc: strobes=%0d, want 3", got);
    else pass_n++;
    switch_mode(5);
    smax = -100000;
    smin = 100000;
    push(16, -17000, 17000, 1'b0);
    mon_en = 1'b1;
    collect(16, got);
    tot_n++;
    if (got != 16 || smax < 12000 || smin > -12000)
      $display("FAIL loop_sine: strobes=%0d max=%0d min=%0d, want 16 >12000 <-12000",
               got, smax, smin);
    else
      pass_n++;
  endtask

  initial begin
    test_reset;
    test_period("full_pos");
    test_const(0, -32768, 1'b0);
    test_const(2, 0, 1'b0);
    test_const(3, 16384, 1'b0);
    test_mid_reset;
    test_closed_loop;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
